// File: rtl/cpu_attack_sched.sv
// CPU opponent attack sequencer: on each rising edge of the random CPU clock picks an attack and
// runs windup -> strike handshake -> recover. Define CPU_ATTACK_STATS_EN for attack/block counters.
module cpu_attack_sched #(
  parameter int unsigned WINDUP_CYC  = 16,
  parameter int unsigned RECOVER_CYC = 8,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cpu_clk,
  input  logic [3:0] i_rand,
  input  logic       i_enable,
  input  logic       i_player_block,
  input  logic       i_attack_ack,
  output logic       o_attack_valid,
  output logic [1:0] o_attack_type,
  output logic [1:0] o_state,
  output logic       o_blocked,
  output logic       o_missed_tick
`ifdef CPU_ATTACK_STATS_EN
  ,
  output logic [15:0] o_light_cnt,
  output logic [15:0] o_heavy_cnt,
  output logic [15:0] o_block_cnt
`endif
);

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWindup  = 2'b01,
    StStrike  = 2'b10,
    StRecover = 2'b11
  } state_e;

  localparam logic [1:0] TypeStandby = 2'b00;
  localparam logic [1:0] TypeLight   = 2'b01;
  localparam logic [1:0] TypeHeavy   = 2'b10;

  localparam logic [CNT_W-1:0] WindupLight  = CNT_W'(WINDUP_CYC - 1);
  localparam logic [CNT_W-1:0] WindupHeavy  = CNT_W'(2 * WINDUP_CYC - 1);
  localparam logic [CNT_W-1:0] RecoverLight = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] RecoverHeavy = CNT_W'(2 * RECOVER_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       type_q, type_d;
  logic             valid_q, valid_d;
  logic             blocked_q, blocked_d;
  logic             missed_q, missed_d;
  logic             cpu_clk_q;
  // Masks the first cycle after reset so a high i_cpu_clk is not seen as an edge.
  logic             armed_q;

  logic             tick;
  logic [CNT_W-1:0] rec_load;

  assign tick     = i_cpu_clk & ~cpu_clk_q & armed_q;
  assign rec_load = (type_q == TypeHeavy) ? RecoverHeavy : RecoverLight;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    valid_d   = valid_q;
    blocked_d = 1'b0;
    missed_d  = tick & (state_q != StIdle);

    if (state_q != StIdle && !i_enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (tick && i_enable) begin
            case (i_rand[3:2])
              2'b00: type_d = TypeStandby;
              2'b11: begin
                type_d  = TypeHeavy;
                state_d = StWindup;
                cnt_d   = WindupHeavy;
              end
              default: begin
                type_d  = TypeLight;
                state_d = StWindup;
                cnt_d   = WindupLight;
              end
            endcase
          end
        end
        StWindup: begin
          // Block takes priority over the final windup cycle.
          if (i_player_block) begin
            state_d   = StRecover;
            cnt_d     = rec_load;
            blocked_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = StStrike;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StStrike: begin
          if (valid_q && i_attack_ack) begin
            state_d = StRecover;
            valid_d = 1'b0;
            cnt_d   = rec_load;
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      type_q    <= TypeStandby;
      valid_q   <= 1'b0;
      blocked_q <= 1'b0;
      missed_q  <= 1'b0;
      cpu_clk_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      valid_q   <= valid_d;
      blocked_q <= blocked_d;
      missed_q  <= missed_d;
      cpu_clk_q <= i_cpu_clk;
      armed_q   <= 1'b1;
    end
  end

  assign o_state        = state_q;
  assign o_attack_valid = valid_q;
  assign o_attack_type  = type_q;
  assign o_blocked      = blocked_q;
  assign o_missed_tick  = missed_q;

`ifdef CPU_ATTACK_STATS_EN
  logic [15:0] light_cnt_q, light_cnt_d;
  logic [15:0] heavy_cnt_q, heavy_cnt_d;
  logic [15:0] block_cnt_q, block_cnt_d;
  logic        ack_fire;

  assign ack_fire = valid_q & i_attack_ack;

  always_comb begin
    light_cnt_d = light_cnt_q;
    heavy_cnt_d = heavy_cnt_q;
    block_cnt_d = block_cnt_q;
    if (ack_fire && type_q == TypeLight && light_cnt_q != 16'hFFFF) begin
      light_cnt_d = light_cnt_q + 16'd1;
    end
    if (ack_fire && type_q == TypeHeavy && heavy_cnt_q != 16'hFFFF) begin
      heavy_cnt_d = heavy_cnt_q + 16'd1;
    end
    if (blocked_d && block_cnt_q != 16'hFFFF) begin
      block_cnt_d = block_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      light_cnt_q <= '0;
      heavy_cnt_q <= '0;
      block_cnt_q <= '0;
    end else begin
      light_cnt_q <= light_cnt_d;
      heavy_cnt_q <= heavy_cnt_d;
      block_cnt_q <= block_cnt_d;
    end
  end

  assign o_light_cnt = light_cnt_q;
  assign o_heavy_cnt = heavy_cnt_q;
  assign o_block_cnt = block_cnt_q;
`endif

endmodule
